dcm_lock_supervisor: RTL and testbench
======================================

// Module: dcm_lock_supervisor
// PURPOSE
//  Parametrised lock watchdog for NUM_CHANNELS DCM_SP instances fed from crystal_clk.
//  Per channel: synchronises LOCKED, pulses the DCM reset when lock does not arrive within
//  a timeout, qualifies lock as stable, detects lock loss and latches a fault after a
//  bounded number of failed retries. Sits beside the clock-generation DCMs and drives their RST pins.
// PARAMETERS
//  NUM_CHANNELS   3      number of supervised DCMs (1..8)
//  TIMER_WIDTH    16     width of the per-channel timeout counter
//  LOCK_TIMEOUT   50000  crystal_clk cycles in WAIT_LOCK before a reset pulse (2..2**TIMER_WIDTH-1)
//  RESET_CYCLES   10     dcm_reset pulse width in cycles (>=3, DCM_SP minimum)
//  SETTLE_CYCLES  16     consecutive synced-lock cycles required before clk_good (>=1)
//  MAX_RETRIES    4      consecutive failed attempts before FAULT (1..15; 0 = retry forever)
// PORTS
//  crystal_clk    in   1       board oscillator clock; all logic on its rising edge
//  reset          in   1       asynchronous, active-high reset
//  dcm_locked     in   N       LOCKED from each DCM (asynchronous to this block)
//  clear_fault    in   N       one-cycle request to restart a channel in FAULT
//  dcm_reset      out  N       active-high RST to each DCM
//  clk_good       out  N       channel locked and stable
//  all_clk_good   out  1       AND of all clk_good bits
//  fault          out  N       channel exhausted MAX_RETRIES
//  lock_lost      out  N       sticky: channel lost lock after having been good
//  retry_count    out  4*N     per-channel consecutive failed attempts, saturating at 15
// BEHAVIOUR
//  - Reset (async): all outputs 0, every channel in WAIT_LOCK, timers/counters 0, sync flops 0.
//    Asserting reset mid-pulse deasserts dcm_reset immediately.
//  - dcm_locked[i] passes through a 2-flop synchroniser -> s[i]; FSM uses s[i] only.
//  - Per-channel FSM, all outputs registered (decoded from state/flags, no comb paths from inputs):
//   WAIT_LOCK: timer++ each cycle. s=1 -> SETTLE (cnt=0). Else on timer==LOCK_TIMEOUT-1:
//     if MAX_RETRIES!=0 and retry_count==MAX_RETRIES -> FAULT; else retry_count++ and -> RESET_PULSE.
//     s=1 in the timeout cycle wins (go SETTLE, no retry).
//   RESET_PULSE: dcm_reset=1 for exactly RESET_CYCLES cycles, s ignored; then WAIT_LOCK, timer=0.
//   SETTLE: cnt++ while s=1; s=0 -> WAIT_LOCK (timer=0, no retry charged);
//     cnt==SETTLE_CYCLES-1 with s=1 -> LOCKED, retry_count cleared to 0.
//   LOCKED: clk_good=1. s=0 -> WAIT_LOCK (timer=0), clk_good drops next edge, lock_lost set.
//   FAULT: fault=1, dcm_reset=0, s ignored. clear_fault[i] -> RESET_PULSE, retry_count=0,
//     fault and lock_lost cleared. clear_fault outside FAULT is ignored.
//  - Latency: stable dcm_locked rise -> clk_good rise = SETTLE_CYCLES+3 edges exactly.
//    WAIT_LOCK entry -> dcm_reset rise = LOCK_TIMEOUT edges.
//  - retry_count saturates at 15 (only reachable with MAX_RETRIES=0); timer never wraps.
//  - Channels fully independent; all_clk_good = &clk_good (no extra flop stage).
// TESTING
//  1 N=3, SETTLE=16, all dcm_locked rise at cycle 100 -> each clk_good=1 at cycle 119, all_clk_good=1.
//  2 LOCK_TIMEOUT=100, RESET_CYCLES=10, ch0 never locks -> dcm_reset[0] high cycles 100..109 after
//    reset release, next pulse at 210; retry_count[0] steps 1,2,3,4; 5th timeout -> fault[0]=1, dcm_reset[0]=0.
//  3 ch1 in FAULT, pulse clear_fault[1] -> 10-cycle dcm_reset[1] pulse, fault[1]=0, retry_count[1]=0;
//    clear_fault[1] while LOCKED -> no change.
//  4 ch2 LOCKED, drop dcm_locked[2] for 1 cycle -> clk_good[2]=0 3 edges later, lock_lost[2]=1 sticky,
//    clk_good[2] back after SETTLE_CYCLES+3; ch0/ch1 unaffected.
//  5 lock glitches high for 5 cycles in SETTLE -> no clk_good, no retry charged; dcm_locked rising on
//    timeout cycle -> SETTLE, no dcm_reset.
//  6 assert reset during dcm_reset pulse -> dcm_reset=0 before next edge; all outputs 0, retries 0.

Source files
------------

// File: rtl/dcm_lock_supervisor.sv
// Lock watchdog for a bank of DCM_SP instances clocked from the board crystal.
// Each channel synchronises LOCKED, kicks the DCM with a reset pulse when lock
// is late, qualifies lock as stable, flags lock loss and gives up after a
// bounded number of consecutive failed attempts until software clears it.
module dcm_lock_supervisor #(
    parameter int NUM_CHANNELS  = 3,
    parameter int TIMER_WIDTH   = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int RESET_CYCLES  = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int MAX_RETRIES   = 4
) (
    input  logic                        crystal_clk,
    input  logic                        reset,
    input  logic [NUM_CHANNELS-1:0]     dcm_locked,
    input  logic [NUM_CHANNELS-1:0]     clear_fault,
    output logic [NUM_CHANNELS-1:0]     dcm_reset,
    output logic [NUM_CHANNELS-1:0]     clk_good,
    output logic                        all_clk_good,
    output logic [NUM_CHANNELS-1:0]     fault,
    output logic [NUM_CHANNELS-1:0]     lock_lost,
    output logic [4*NUM_CHANNELS-1:0]   retry_count
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_RESET_PULSE = 3'd1,
        ST_SETTLE      = 3'd2,
        ST_LOCKED      = 3'd3,
        ST_FAULT       = 3'd4
    } state_t;

    // One counter per channel serves as lock timer, pulse timer and settle
    // counter; only one of those is ever running in a given state.
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] PULSE_LAST   = TIMER_WIDTH'(RESET_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] SETTLE_LAST  = TIMER_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] CNT_ONE      = TIMER_WIDTH'(1);
    localparam logic [3:0]             RETRY_LIMIT  = 4'(MAX_RETRIES);
    localparam logic                   RETRY_BOUNDED = (MAX_RETRIES != 0);

    logic [NUM_CHANNELS-1:0] sync_meta_r;
    logic [NUM_CHANNELS-1:0] sync_r;

    // Two-flop synchroniser for the asynchronous LOCKED inputs.
    always_ff @(posedge crystal_clk or posedge reset) begin
        if (reset) begin
            sync_meta_r <= '0;
            sync_r      <= '0;
        end else begin
            sync_meta_r <= dcm_locked;
            sync_r      <= sync_meta_r;
        end
    end

    genvar ch;
    generate
        for (ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
            state_t                   state_r, state_s;
            logic [TIMER_WIDTH-1:0]   cnt_r, cnt_s;
            logic [3:0]               retry_r, retry_s;
            logic                     lost_r, lost_s;
            logic                     dcm_reset_r, clk_good_r, fault_r;
            logic                     locked_s;

            assign locked_s = sync_r[ch];

            // Next-state, counter and retry bookkeeping for this channel.
            always_comb begin
                state_s = state_r;
                cnt_s   = cnt_r;
                retry_s = retry_r;
                lost_s  = lost_r;
                case (state_r)
                    ST_WAIT_LOCK: begin
                        if (locked_s) begin
                            // Lock arriving on the timeout cycle still wins.
                            state_s = ST_SETTLE;
                            cnt_s   = '0;
                        end else if (cnt_r == TIMEOUT_LAST) begin
                            cnt_s = '0;
                            if (RETRY_BOUNDED && (retry_r == RETRY_LIMIT)) begin
                                state_s = ST_FAULT;
                            end else begin
                                state_s = ST_RESET_PULSE;
                                retry_s = (retry_r == 4'd15) ? retry_r : (retry_r + 4'd1);
                            end
                        end else begin
                            cnt_s = cnt_r + CNT_ONE;
                        end
                    end
                    ST_RESET_PULSE: begin
                        if (cnt_r == PULSE_LAST) begin
                            state_s = ST_WAIT_LOCK;
                            cnt_s   = '0;
                        end else begin
                            cnt_s = cnt_r + CNT_ONE;
                        end
                    end
                    ST_SETTLE: begin
                        if (!locked_s) begin
                            // A glitch is not a failed attempt; just resume waiting.
                            state_s = ST_WAIT_LOCK;
                            cnt_s   = '0;
                        end else if (cnt_r == SETTLE_LAST) begin
                            state_s = ST_LOCKED;
                            cnt_s   = '0;
                            retry_s = 4'd0;
                        end else begin
                            cnt_s = cnt_r + CNT_ONE;
                        end
                    end
                    ST_LOCKED: begin
                        if (!locked_s) begin
                            state_s = ST_WAIT_LOCK;
                            cnt_s   = '0;
                            lost_s  = 1'b1;
                        end else begin
                            state_s = ST_LOCKED;
                        end
                    end
                    ST_FAULT: begin
                        if (clear_fault[ch]) begin
                            state_s = ST_RESET_PULSE;
                            cnt_s   = '0;
                            retry_s = 4'd0;
                            lost_s  = 1'b0;
                        end else begin
                            state_s = ST_FAULT;
                        end
                    end
                    default: begin
                        state_s = ST_WAIT_LOCK;
                        cnt_s   = '0;
                    end
                endcase
            end

            // State, counters and outputs registered from the next state.
            always_ff @(posedge crystal_clk or posedge reset) begin
                if (reset) begin
                    state_r     <= ST_WAIT_LOCK;
                    cnt_r       <= '0;
                    retry_r     <= 4'd0;
                    lost_r      <= 1'b0;
                    dcm_reset_r <= 1'b0;
                    clk_good_r  <= 1'b0;
                    fault_r     <= 1'b0;
                end else begin
                    state_r     <= state_s;
                    cnt_r       <= cnt_s;
                    retry_r     <= retry_s;
                    lost_r      <= lost_s;
                    dcm_reset_r <= (state_s == ST_RESET_PULSE);
                    clk_good_r  <= (state_s == ST_LOCKED);
                    fault_r     <= (state_s == ST_FAULT);
                end
            end

            assign dcm_reset[ch]          = dcm_reset_r;
            assign clk_good[ch]           = clk_good_r;
            assign fault[ch]              = fault_r;
            assign lock_lost[ch]          = lost_r;
            assign retry_count[4*ch +: 4] = retry_r;
        end
    endgenerate

    assign all_clk_good = &clk_good;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Bench for dcm_lock_supervisor: scripted scenarios with hand-computed cycle
// expectations, then randomized LOCKED/clear_fault/reset activity, all checked
// every cycle against a timestamp-based behavioural model of each channel.
module tb_dcm_lock_supervisor;

    localparam int N      = 3;
    localparam int LT     = 100;
    localparam int RC     = 10;
    localparam int SETTLE = 16;
    localparam int MAXR   = 4;

    logic             crystal_clk;
    logic             reset;
    logic [N-1:0]     dcm_locked;
    logic [N-1:0]     clear_fault;
    logic [N-1:0]     dcm_reset;
    logic [N-1:0]     clk_good;
    logic             all_clk_good;
    logic [N-1:0]     fault;
    logic [N-1:0]     lock_lost;
    logic [4*N-1:0]   retry_count;

    dcm_lock_supervisor #(
        .NUM_CHANNELS (N),
        .TIMER_WIDTH  (16),
        .LOCK_TIMEOUT (LT),
        .RESET_CYCLES (RC),
        .SETTLE_CYCLES(SETTLE),
        .MAX_RETRIES  (MAXR)
    ) dut (
        .crystal_clk (crystal_clk),
        .reset       (reset),
        .dcm_locked  (dcm_locked),
        .clear_fault (clear_fault),
        .dcm_reset   (dcm_reset),
        .clk_good    (clk_good),
        .all_clk_good(all_clk_good),
        .fault       (fault),
        .lock_lost   (lock_lost),
        .retry_count (retry_count)
    );

    initial crystal_clk = 1'b0;
    always #5 crystal_clk = ~crystal_clk;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", name, idx, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is described by what it is doing and the edge number at
    // which it started doing it; timeouts are measured as elapsed edges.
    localparam int HUNT = 0, KICK = 1, QUALIFY = 2, GOOD = 3, DEAD = 4;
    int edge_no;
    int phase[N];
    int since[N];
    int fails[N];
    bit lost[N];
    bit pipe1[N];
    bit pipe2[N];

    always @(posedge crystal_clk or posedge reset) begin
        if (reset) begin
            edge_no = 0;
            for (int i = 0; i < N; i++) begin
                phase[i] = HUNT; since[i] = 0; fails[i] = 0;
                lost[i] = 1'b0; pipe1[i] = 1'b0; pipe2[i] = 1'b0;
            end
        end else begin
            edge_no++;
            for (int i = 0; i < N; i++) begin
                bit s;
                int age;
                s   = pipe2[i];
                age = edge_no - since[i];
                case (phase[i])
                    HUNT: begin
                        if (s) begin
                            phase[i] = QUALIFY; since[i] = edge_no;
                        end else if (age == LT) begin
                            if (MAXR != 0 && fails[i] == MAXR) begin
                                phase[i] = DEAD; since[i] = edge_no;
                            end else begin
                                fails[i] = (fails[i] + 1 > 15) ? 15 : fails[i] + 1;
                                phase[i] = KICK; since[i] = edge_no;
                            end
                        end
                    end
                    KICK: if (age == RC) begin phase[i] = HUNT; since[i] = edge_no; end
                    QUALIFY: begin
                        if (!s) begin
                            phase[i] = HUNT; since[i] = edge_no;
                        end else if (age == SETTLE) begin
                            phase[i] = GOOD; since[i] = edge_no; fails[i] = 0;
                        end
                    end
                    GOOD: if (!s) begin phase[i] = HUNT; since[i] = edge_no; lost[i] = 1'b1; end
                    DEAD: if (clear_fault[i]) begin
                        phase[i] = KICK; since[i] = edge_no; fails[i] = 0; lost[i] = 1'b0;
                    end
                    default: phase[i] = HUNT;
                endcase
                pipe2[i] = pipe1[i];
                pipe1[i] = dcm_locked[i];
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge crystal_clk) begin
        if (checking && !reset) begin
            bit all_good;
            all_good = 1'b1;
            for (int i = 0; i < N; i++) begin
                check("dcm_reset",   i, 32'(dcm_reset[i]), 32'(phase[i] == KICK));
                check("clk_good",    i, 32'(clk_good[i]),  32'(phase[i] == GOOD));
                check("fault",       i, 32'(fault[i]),     32'(phase[i] == DEAD));
                check("lock_lost",   i, 32'(lock_lost[i]), 32'(lost[i]));
                check("retry_count", i, 32'(retry_count[4*i +: 4]), 32'(fails[i]));
                if (phase[i] != GOOD) all_good = 1'b0;
            end
            check("all_clk_good", 0, 32'(all_clk_good), 32'(all_good));
        end
    end

    // ---------------- stimulus ----------------
    int cur;

    task automatic step(input int n);
        repeat (n) @(posedge crystal_clk);
        #2;
        cur += n;
    endtask

    task automatic goto_edge(input int k);
        if (k > cur) step(k - cur);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge crystal_clk);
        @(negedge crystal_clk);
        reset = 1'b0;
        cur = 0;
    endtask

    initial begin
        reset = 1'b1; dcm_locked = '0; clear_fault = '0; cur = 0;
        checking = 1'b1;
        do_reset();
        check("rst_dcm_reset", 0, 32'(dcm_reset), 32'd0);
        check("rst_retry", 0, 32'(retry_count), 32'd0);

        // All DCMs lock together: clk_good exactly SETTLE+3 edges later.
        goto_edge(50); dcm_locked = 3'b111;
        goto_edge(68); check("t1_clk_good_early", 0, 32'(clk_good), 32'd0);
        goto_edge(69); check("t1_clk_good", 0, 32'(clk_good), 32'd7);
        check("t1_all_good", 0, 32'(all_clk_good), 32'd1);

        // One-cycle loss on ch2.
        goto_edge(80); dcm_locked[2] = 1'b0;
        goto_edge(81); dcm_locked[2] = 1'b1;
        goto_edge(82); check("t4_still_good", 2, 32'(clk_good[2]), 32'd1);
        goto_edge(83); check("t4_drop", 2, 32'(clk_good[2]), 32'd0);
        check("t4_lost", 2, 32'(lock_lost[2]), 32'd1);
        check("t4_others", 0, 32'(clk_good[1:0]), 32'd3);
        goto_edge(99);  check("t4_back_early", 2, 32'(clk_good[2]), 32'd0);
        goto_edge(100); check("t4_back", 2, 32'(clk_good[2]), 32'd1);
        check("t4_lost_sticky", 2, 32'(lock_lost[2]), 32'd1);

        // clear_fault while locked is ignored.
        clear_fault = 3'b010;
        goto_edge(101); clear_fault = '0;
        goto_edge(102); check("t3_ignored", 1, 32'(clk_good), 32'd7);

        // Retry/fault sequence on ch0/ch1; ch2 locks on its timeout cycle.
        do_reset(); dcm_locked = '0;
        goto_edge(97); dcm_locked[2] = 1'b1;
        goto_edge(99);  check("t2_no_pulse_yet", 0, 32'(dcm_reset), 32'd0);
        goto_edge(100); check("t2_pulse", 0, 32'(dcm_reset), 32'd3);
        check("t2_retry1", 0, 32'(retry_count[3:0]), 32'd1);
        goto_edge(109); check("t2_pulse_end", 0, 32'(dcm_reset[0]), 32'd1);
        goto_edge(110); check("t2_pulse_off", 0, 32'(dcm_reset[0]), 32'd0);
        goto_edge(116); check("t5_timeout_lock", 2, 32'(clk_good[2]), 32'd1);
        goto_edge(209); check("t2_gap", 0, 32'(dcm_reset[0]), 32'd0);
        goto_edge(210); check("t2_pulse2", 0, 32'(dcm_reset[0]), 32'd1);
        check("t2_retry2", 0, 32'(retry_count[3:0]), 32'd2);
        goto_edge(320); check("t2_retry3", 0, 32'(retry_count[3:0]), 32'd3);
        goto_edge(430); check("t2_retry4", 0, 32'(retry_count[3:0]), 32'd4);
        goto_edge(539); check("t2_no_fault", 0, 32'(fault[0]), 32'd0);
        goto_edge(540); check("t2_fault", 0, 32'(fault), 32'd3);
        check("t2_fault_no_rst", 0, 32'(dcm_reset[0]), 32'd0);

        // Clear the fault on ch1 only.
        goto_edge(545); clear_fault = 3'b010;
        goto_edge(546); clear_fault = '0;
        check("t3_pulse", 1, 32'(dcm_reset[1]), 32'd1);
        check("t3_fault_clr", 1, 32'(fault), 32'd1);
        check("t3_retry_clr", 1, 32'(retry_count[7:4]), 32'd0);
        goto_edge(555); check("t3_pulse_end", 1, 32'(dcm_reset[1]), 32'd1);
        goto_edge(556); check("t3_pulse_off", 1, 32'(dcm_reset[1]), 32'd0);

        // Five-cycle glitch while settling: no lock, no retry charged.
        goto_edge(560); dcm_locked[1] = 1'b1;
        goto_edge(565); dcm_locked[1] = 1'b0;
        goto_edge(600); check("t5_no_good", 1, 32'(clk_good[1]), 32'd0);
        check("t5_no_retry", 1, 32'(retry_count[7:4]), 32'd0);
        goto_edge(668); check("t5_timer_restart", 1, 32'(dcm_reset[1]), 32'd1);

        // Reset during a pulse clears everything without waiting for an edge.
        goto_edge(670);
        reset = 1'b1;
        #1;
        check("t6_dcm_reset", 0, 32'(dcm_reset), 32'd0);
        check("t6_fault", 0, 32'(fault), 32'd0);
        check("t6_retry", 0, 32'(retry_count), 32'd0);
        check("t6_good", 0, 32'(clk_good), 32'd0);
        check("t6_lost", 0, 32'(lock_lost), 32'd0);
        do_reset();

        // Randomized activity checked by the model every cycle.
        for (int seg = 0; seg < 80; seg++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 2) == 0) dcm_locked[i] = ~dcm_locked[i];
            clear_fault = 3'($urandom_range(0, 7));
            step(1);
            clear_fault = '0;
            step($urandom_range(1, 120));
            if (seg % 25 == 24) do_reset();
        end

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
